pll_rst_seq: RTL and testbench

- Reset/lock sequencer for a PLLE4_ADV.
- Runs in the PLL input-clock domain, the IBUFDS output ahead of the PLL.
- Drives the PLL RST pin, watches LOCKED, and releases an active-high fabric reset (`sys_rst`) only after lock has been stable. The per-domain reset synchronisers in the consuming clock domains take `sys_rst`.
- Retries on lock timeout, re-sequences on lock loss, and latches a hard-fail flag after too many retries.

---
 rtl/pll_seq_pkg.sv | 21 ++
 rtl/bit_sync.sv | 22 ++
 rtl/pll_rst_seq.sv | 124 ++++++++++++
 tb/tb_pll_rst_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reset/lock sequencer: FSM state encoding and
// the retry-counter width.
package pll_seq_pkg;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser with asynchronous active-low clear; output is 0
// while cleared and follows d two clk edges later otherwise.
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset/lock sequencer: pulses PLL RST, waits for a stable LOCKED and
// only then releases the fabric reset; retries, re-sequences and hard-fails.
module pll_rst_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRY    = 7,
  parameter int LOSS_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               locked_i,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               running,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  loss_cnt,
  output logic [2:0]         state_dbg
);

  localparam int TMAX = max3(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]      RST_LAST   = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0]      TO_LAST    = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]      STB_LAST   = TW'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRY);

  // Handshake note: relock_req is a single-cycle strobe, sampled on every
  // clk edge; there is no ready/ack, a strobe seen in PLL_RST is dropped.

  pll_state_t         state, state_n;
  logic [TW-1:0]      timer, timer_n;
  logic [RETRY_W-1:0] retry_n;
  logic [LOSS_W-1:0]  loss_n;
  logic               locked_s;

  bit_sync u_lock_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (locked_i),
    .q     (locked_s)
  );

  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    retry_n = retry_cnt;
    loss_n  = loss_cnt;
    if (relock_req && state != PLL_RST) begin
      state_n = PLL_RST;
      if (state == FAIL) retry_n = '0;
      if (state == RUN && !locked_s && loss_cnt != '1) loss_n = loss_cnt + 1'b1;
    end else begin
      case (state)
        PLL_RST: begin
          if (timer == RST_LAST) state_n = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_n = STABLE;
          end else if (timer == TO_LAST) begin
            retry_n = retry_cnt + 1'b1;
            state_n = (retry_n == RETRY_LIM) ? FAIL : PLL_RST;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_n = WAIT_LOCK;
          end else if (timer == STB_LAST) begin
            state_n = RUN;
            retry_n = '0;
          end
        end
        RUN: begin
          timer_n = timer;
          if (!locked_s) begin
            state_n = PLL_RST;
            if (loss_cnt != '1) loss_n = loss_cnt + 1'b1;
          end
        end
        FAIL: begin
          timer_n = timer;
        end
        default: begin
          state_n = PLL_RST;
        end
      endcase
    end
    // Every phase measures its own duration from zero.
    if (state_n != state) timer_n = '0;
  end

  // Outputs are registered from the next state so they change in the same
  // cycle the registered state does, without decode glitches on PLL RST.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PLL_RST;
      timer     <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      running   <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      retry_cnt <= retry_n;
      loss_cnt  <= loss_n;
      pll_rst   <= (state_n == PLL_RST) || (state_n == FAIL);
      sys_rst   <= (state_n != RUN);
      running   <= (state_n == RUN);
      fail      <= (state_n == FAIL);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with small parameters: a vector table of
// per-cycle checkpoints plus hand-written loss, saturation and async-reset runs.
module tb_pll_rst_seq;

  localparam int EW = 19;

  logic       clk;
  logic       rst;
  logic       locked_i;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       running;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state_dbg;

  pll_rst_seq #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .LOCK_STABLE  (8),
    .MAX_RETRY    (2),
    .LOSS_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .locked_i   (locked_i),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .running    (running),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int cur    = 0;

  typedef struct {
    bit            rf;
    int            cyc;
    bit            lk;
    bit            rq;
    logic [EW-1:0] exp;
    string         nm;
  } vec_t;

  vec_t tbl[$];

  // {state, pll_rst, sys_rst, running, fail, retry_cnt, loss_cnt}
  function automatic logic [EW-1:0] ex(input int st, input bit p, input bit s,
                                       input bit u, input bit f, input int rt,
                                       input int ls);
    return {3'(st), p, s, u, f, 4'(rt), 8'(ls)};
  endfunction

  function automatic vec_t row(input bit rf, input int cyc, input bit lk,
                               input bit rq, input logic [EW-1:0] e,
                               input string nm);
    vec_t v;
    v.rf = rf; v.cyc = cyc; v.lk = lk; v.rq = rq; v.exp = e; v.nm = nm;
    return v;
  endfunction

  task automatic chk(input logic [EW-1:0] e, input string nm);
    logic [EW-1:0] act, want;
    exp_q.push_back(e);
    want = exp_q.pop_front();
    act  = {state_dbg, pll_rst, sys_rst, running, fail, retry_cnt, loss_cnt};
    n_chk++;
    if (act === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s cyc=%0d got st=%0d pll=%b sys=%b run=%b fail=%b retry=%0d loss=%0d want st=%0d pll=%b sys=%b run=%b fail=%b retry=%0d loss=%0d",
               nm, cur, act[18:16], act[15], act[14], act[13], act[12], act[11:8], act[7:0],
               want[18:16], want[15], want[14], want[13], want[12], want[11:8], want[7:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cur++;
    relock_req = 1'b0;
  endtask

  task automatic goto(input int c);
    while (cur < c) step();
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    locked_i   = 1'b0;
    relock_req = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cur = 0;
  endtask

  task automatic wait_state(input logic [2:0] st, input string nm);
    int n;
    n = 0;
    while (state_dbg !== st && n < 40) begin
      step();
      n++;
    end
    if (state_dbg !== st) begin
      n_chk++;
      $display("FAIL %s timeout got st=%0d want st=%0d", nm, state_dbg, st);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1'b0; locked_i = 1'b0; relock_req = 1'b0;

    // Normal bring-up: lock arrives at cycle 10.
    tbl.push_back(row(1,  0, 0, 0, ex(0,1,1,0,0,0,0), "t1_c0"));
    tbl.push_back(row(0,  3, 0, 0, ex(0,1,1,0,0,0,0), "t1_rst_last"));
    tbl.push_back(row(0,  4, 0, 0, ex(1,0,1,0,0,0,0), "t1_wait"));
    tbl.push_back(row(0, 10, 1, 0, ex(1,0,1,0,0,0,0), "t1_lock_up"));
    tbl.push_back(row(0, 12, 1, 0, ex(1,0,1,0,0,0,0), "t1_sync_lat"));
    tbl.push_back(row(0, 13, 1, 0, ex(2,0,1,0,0,0,0), "t1_stable"));
    tbl.push_back(row(0, 20, 1, 0, ex(2,0,1,0,0,0,0), "t1_stable_last"));
    tbl.push_back(row(0, 21, 1, 0, ex(3,0,0,1,0,0,0), "t1_run"));
    // No lock: two timeouts then FAIL, then relock_req.
    tbl.push_back(row(1,  0, 0, 0, ex(0,1,1,0,0,0,0), "t2_c0"));
    tbl.push_back(row(0,  4, 0, 0, ex(1,0,1,0,0,0,0), "t2_wait"));
    tbl.push_back(row(0, 35, 0, 0, ex(1,0,1,0,0,0,0), "t2_to_edge"));
    tbl.push_back(row(0, 36, 0, 0, ex(0,1,1,0,0,1,0), "t2_retry1"));
    tbl.push_back(row(0, 39, 0, 0, ex(0,1,1,0,0,1,0), "t2_rst2_last"));
    tbl.push_back(row(0, 40, 0, 0, ex(1,0,1,0,0,1,0), "t2_wait2"));
    tbl.push_back(row(0, 71, 0, 0, ex(1,0,1,0,0,1,0), "t2_to_edge2"));
    tbl.push_back(row(0, 72, 0, 0, ex(4,1,1,0,1,2,0), "t2_fail"));
    tbl.push_back(row(0, 80, 0, 1, ex(4,1,1,0,1,2,0), "t2_fail_hold"));
    tbl.push_back(row(0, 81, 0, 0, ex(0,1,1,0,0,0,0), "t2_relock"));
    tbl.push_back(row(0, 84, 0, 0, ex(0,1,1,0,0,0,0), "t2_rst3_last"));
    tbl.push_back(row(0, 85, 0, 0, ex(1,0,1,0,0,0,0), "t2_wait3"));
    tbl.push_back(row(0,117, 0, 0, ex(0,1,1,0,0,1,0), "t2_retry_again"));
    // Lock glitch in STABLE, lock losses in RUN, relock_req in RUN.
    tbl.push_back(row(1,  0, 1, 0, ex(0,1,1,0,0,0,0), "t3_c0"));
    tbl.push_back(row(0,  4, 1, 0, ex(1,0,1,0,0,0,0), "t3_wait"));
    tbl.push_back(row(0,  5, 1, 0, ex(2,0,1,0,0,0,0), "t3_stable"));
    tbl.push_back(row(0,  9, 0, 0, ex(2,0,1,0,0,0,0), "t3_drop"));
    tbl.push_back(row(0, 10, 1, 0, ex(2,0,1,0,0,0,0), "t3_drop_sync1"));
    tbl.push_back(row(0, 11, 1, 0, ex(2,0,1,0,0,0,0), "t3_drop_sync2"));
    tbl.push_back(row(0, 12, 1, 0, ex(1,0,1,0,0,0,0), "t3_back_wait"));
    tbl.push_back(row(0, 13, 1, 0, ex(2,0,1,0,0,0,0), "t3_stable2"));
    tbl.push_back(row(0, 20, 1, 0, ex(2,0,1,0,0,0,0), "t3_full8"));
    tbl.push_back(row(0, 21, 1, 0, ex(3,0,0,1,0,0,0), "t3_run"));
    tbl.push_back(row(0, 25, 0, 0, ex(3,0,0,1,0,0,0), "t4_drop1"));
    tbl.push_back(row(0, 26, 1, 0, ex(3,0,0,1,0,0,0), "t4_drop1_b"));
    tbl.push_back(row(0, 27, 1, 0, ex(3,0,0,1,0,0,0), "t4_drop1_c"));
    tbl.push_back(row(0, 28, 1, 0, ex(0,1,1,0,0,0,1), "t4_loss1"));
    tbl.push_back(row(0, 40, 1, 0, ex(2,0,1,0,0,0,1), "t4_loss1_stable"));
    tbl.push_back(row(0, 41, 1, 0, ex(3,0,0,1,0,0,1), "t4_loss1_run"));
    tbl.push_back(row(0, 45, 0, 0, ex(3,0,0,1,0,0,1), "t4_drop2"));
    tbl.push_back(row(0, 46, 1, 0, ex(3,0,0,1,0,0,1), "t4_drop2_b"));
    tbl.push_back(row(0, 48, 1, 0, ex(0,1,1,0,0,0,2), "t4_loss2"));
    tbl.push_back(row(0, 61, 1, 0, ex(3,0,0,1,0,0,2), "t4_loss2_run"));
    tbl.push_back(row(0, 65, 0, 0, ex(3,0,0,1,0,0,2), "t4_drop3"));
    tbl.push_back(row(0, 66, 1, 0, ex(3,0,0,1,0,0,2), "t4_drop3_b"));
    tbl.push_back(row(0, 68, 1, 0, ex(0,1,1,0,0,0,3), "t4_loss3"));
    tbl.push_back(row(0, 81, 1, 0, ex(3,0,0,1,0,0,3), "t4_loss3_run"));
    tbl.push_back(row(0, 85, 1, 1, ex(3,0,0,1,0,0,3), "t5_relock_run"));
    tbl.push_back(row(0, 86, 1, 0, ex(0,1,1,0,0,0,3), "t5_pll_rst"));
    tbl.push_back(row(0, 87, 1, 1, ex(0,1,1,0,0,0,3), "t5_rq_in_rst"));
    tbl.push_back(row(0, 89, 1, 0, ex(0,1,1,0,0,0,3), "t5_rst_last"));
    tbl.push_back(row(0, 90, 1, 0, ex(1,0,1,0,0,0,3), "t5_no_stretch"));
    tbl.push_back(row(0, 91, 1, 0, ex(2,0,1,0,0,0,3), "t5_stable"));
    tbl.push_back(row(0, 99, 1, 0, ex(3,0,0,1,0,0,3), "t5_run_again"));

    // Reset values while rst is held low.
    @(posedge clk);
    #1;
    chk(ex(0,1,1,0,0,0,0), "reset_hold");

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rf) do_reset();
      goto(tbl[i].cyc);
      chk(tbl[i].exp, tbl[i].nm);
      locked_i   = tbl[i].lk;
      relock_req = tbl[i].rq;
    end

    // relock_req in RUN in the same cycle locked_s is low: still a loss.
    locked_i = 1'b0; step();
    locked_i = 1'b1; step();
    relock_req = 1'b1; step();
    chk(ex(0,1,1,0,0,0,4), "t5_rq_and_loss");
    wait_state(3'd3, "t5_rq_and_loss_rerun");

    // Drive loss_cnt through the all-ones boundary.
    for (int i = 5; i <= 257; i++) begin
      locked_i = 1'b0; step();
      locked_i = 1'b1; step();
      step();
      chk(ex(0,1,1,0,0,0, (i > 255) ? 255 : i), "t4_sat");
      wait_state(3'd3, "t4_sat_rerun");
    end

    // Async reset in STABLE, no clock edge needed.
    locked_i = 1'b0; step();
    locked_i = 1'b1;
    wait_state(3'd2, "t6_reach_stable");
    step(); step();
    chk(ex(2,0,1,0,0,0,255), "t6_pre_stable");
    #3 rst = 1'b0;
    #1;
    chk(ex(0,1,1,0,0,0,0), "t6_async_stable");

    // Async reset in FAIL.
    do_reset();
    goto(72);
    chk(ex(4,1,1,0,1,2,0), "t6_pre_fail");
    #3 rst = 1'b0;
    #1;
    chk(ex(0,1,1,0,0,0,0), "t6_async_fail");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
